// File: rtl/bram_reader_pkg.sv
// Shared definitions for the BRAM reader: FSM state encoding, default
// beat geometry and the result-buffer constants used alongside it.
package bram_reader_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Default number of BRAM words packed into one output beat (512 / 32)
    localparam int DEFAULT_WORDS_PER_BEAT = 16;

    // Result buffer placement shared with the rest of the accelerator
    localparam int RESULT_BASED_ADDRESS     = 32'h0000_1000;
    localparam int DATA_TILLING_RESULT_SIZE = 4096;

    // Width of a word index inside a beat; never narrower than one bit
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/bram_reader_packer.sv
// Word packer: inserts one BRAM word into its slot of the output beat.
// Slot k occupies bits [DATA_IN_WIDTH*k +: DATA_IN_WIDTH], so the lowest
// address of a beat lands in the least significant bits.
module bram_word_packer #(
    parameter int DATA_IN_WIDTH  = 32,
    parameter int DATA_OUT_WIDTH = 512,
    parameter int IDX_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [IDX_WIDTH-1:0]      idx,
    input  logic [DATA_IN_WIDTH-1:0]  word,
    output logic [DATA_OUT_WIDTH-1:0] beat
);

    // Beat register: cleared at job start, otherwise one slot written per returned word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (wr_en) begin
            beat[idx * DATA_IN_WIDTH +: DATA_IN_WIDTH] <= word;
        end
    end

endmodule

// File: rtl/bram_reader.sv
// BRAM reader: streams a job of N beats out of a BRAM, each beat being
// WORDS_PER_BEAT consecutive words packed LSB-first, with a valid/ready
// handshake on the output and a one-cycle finish pulse at the end.
module bram_reader
    import bram_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 13,
    parameter int REG_WIDTH      = 32,
    parameter int DATA_IN_WIDTH  = 32,
    parameter int DATA_OUT_WIDTH = 512,
    parameter int WORDS_PER_BEAT = DATA_OUT_WIDTH / DATA_IN_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [ADDRESS_WIDTH-1:0]  i_param_cfg_base,
    input  logic [REG_WIDTH-1:0]      i_param_cfg_beats,
    output logic [ADDRESS_WIDTH-1:0]  bram_addr,
    output logic                      bram_en,
    output logic                      bram_we,
    input  logic [DATA_IN_WIDTH-1:0]  bram_data_i,
    output logic [DATA_OUT_WIDTH-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o,
    output logic                      finish_o
);

    localparam int IDX_WIDTH = idx_width(WORDS_PER_BEAT);
    localparam logic [IDX_WIDTH-1:0] LAST_WORD = IDX_WIDTH'(WORDS_PER_BEAT - 1);

    logic [2:0]           state;
    logic [IDX_WIDTH-1:0] word_cnt;
    logic [REG_WIDTH-1:0] beats_left;
    logic                 rd_valid;
    logic [IDX_WIDTH-1:0] rd_idx;
    logic                 job_start;
    logic                 pack_clear;
    logic                 handshake;

    // The BRAM port is read-only from this block
    assign bram_we    = 1'b0;
    assign busy_o     = (state != ST_IDLE);
    assign job_start  = (state == ST_IDLE) && start_i;
    assign pack_clear = job_start && (i_param_cfg_beats != '0);
    assign handshake  = (state == ST_HOLD) && valid_o && ready_i;

    // Track which word slot the BRAM will return next cycle (one-cycle read latency)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
        end else begin
            rd_valid <= bram_en;
            rd_idx   <= word_cnt;
        end
    end

    // Job sequencing: issue a burst of reads, drain the last word, hold the beat until accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            bram_addr  <= '0;
            bram_en    <= 1'b0;
            valid_o    <= 1'b0;
            finish_o   <= 1'b0;
            word_cnt   <= '0;
            beats_left <= '0;
        end else begin
            finish_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_start) begin
                        beats_left <= i_param_cfg_beats;
                        if (i_param_cfg_beats != '0) begin
                            state     <= ST_FETCH;
                            bram_en   <= 1'b1;
                            bram_addr <= i_param_cfg_base;
                            word_cnt  <= '0;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    if (word_cnt == LAST_WORD) begin
                        bram_en  <= 1'b0;
                        word_cnt <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        word_cnt  <= word_cnt + IDX_WIDTH'(1);
                        bram_addr <= bram_addr + ADDRESS_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    valid_o <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (handshake) begin
                        valid_o    <= 1'b0;
                        beats_left <= beats_left - REG_WIDTH'(1);
                        if (beats_left != REG_WIDTH'(1)) begin
                            state     <= ST_FETCH;
                            bram_en   <= 1'b1;
                            bram_addr <= bram_addr + ADDRESS_WIDTH'(1);
                            word_cnt  <= '0;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    finish_o <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    bram_en <= 1'b0;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

    bram_word_packer #(
        .DATA_IN_WIDTH (DATA_IN_WIDTH),
        .DATA_OUT_WIDTH(DATA_OUT_WIDTH),
        .IDX_WIDTH     (IDX_WIDTH)
    ) u_packer (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(pack_clear),
        .wr_en(rd_valid),
        .idx  (rd_idx),
        .word (bram_data_i),
        .beat (data_o)
    );

endmodule

// File: tb/tb_bram_reader.sv
// Self-checking bench for bram_reader: a table of jobs plus random jobs,
// each compared cycle by cycle against a timeline model derived from the
// block's documented timing, and a hand-written mid-job reset sequence.
module tb_bram_reader;

    localparam int AW    = 13;
    localparam int RW    = 32;
    localparam int DW    = 32;
    localparam int OW    = 512;
    localparam int WPB   = 16;
    localparam int DEPTH = 8192;
    localparam int MAXC  = 8192;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] i_param_cfg_base = '0;
    logic [RW-1:0] i_param_cfg_beats = '0;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_data_i;
    logic [OW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          busy_o;
    logic          finish_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bram_reader #(
        .ADDRESS_WIDTH (AW),
        .REG_WIDTH     (RW),
        .DATA_IN_WIDTH (DW),
        .DATA_OUT_WIDTH(OW),
        .WORDS_PER_BEAT(WPB)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .i_param_cfg_base (i_param_cfg_base),
        .i_param_cfg_beats(i_param_cfg_beats),
        .bram_addr        (bram_addr),
        .bram_en          (bram_en),
        .bram_we          (bram_we),
        .bram_data_i      (bram_data_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .busy_o           (busy_o),
        .finish_o         (finish_o)
    );

    always #5 clk_i = ~clk_i;

    // BRAM model with one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_i) begin
        if (bram_en) bram_data_i <= mem[bram_addr];
    end

    // Absolute cycle number, advanced on each rising edge
    always @(posedge clk_i) cyc <= cyc + 1;

    // Per-cycle trace of DUT outputs, sampled mid-cycle
    logic          en_log    [MAXC];
    logic [AW-1:0] addr_log  [MAXC];
    logic          valid_log [MAXC];
    logic [OW-1:0] data_log  [MAXC];
    logic          fin_log   [MAXC];
    logic          busy_log  [MAXC];
    bit            ready_log [MAXC];
    bit            we_bad = 1'b0;

    always @(negedge clk_i) begin
        if (cyc < MAXC) begin
            en_log[cyc]    <= bram_en;
            addr_log[cyc]  <= bram_addr;
            valid_log[cyc] <= valid_o;
            data_log[cyc]  <= data_o;
            fin_log[cyc]   <= finish_o;
            busy_log[cyc]  <= busy_o;
        end
        if (bram_we !== 1'b0) we_bad <= 1'b1;
    end

    // Expected timeline produced by the model
    logic          e_en    [MAXC];
    logic [AW-1:0] e_addr  [MAXC];
    logic          e_valid [MAXC];
    logic [OW-1:0] e_data  [MAXC];
    logic          e_fin   [MAXC];
    logic          e_busy  [MAXC];

    typedef struct {
        int          base;
        logic [31:0] beats;
        int          mode;     // 0: ready always, 1: random ready, 2: ready low until rel cycle 28
        bit          perturb;  // scramble config and pulse start while busy
        int          fin_rel;  // expected finish cycle relative to start, -1 = model only
    } vec_t;

    vec_t vecs [7];
    int   t0s  [7];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit pick_ready(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            default: return (n >= 28);
        endcase
    endfunction

    // Pack beat b of a job from the memory image: word k from address base+16b+k mod depth
    function automatic logic [OW-1:0] model_beat(input int base, input int b);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < WPB; k++) r[k*DW +: DW] = mem[(base + b*WPB + k) % DEPTH];
        return r;
    endfunction

    // Start one job and run it until finish (plus a few idle cycles) or a cycle budget expires
    task automatic applyStimulus(input int base, input logic [31:0] beats, input int mode,
                                 input bit perturb, output int t0, output int tend);
        int  budget;
        int  fin_at;
        bit  done;
        step();
        t0 = cyc;
        start_i = 1'b1;
        i_param_cfg_base = AW'(base);
        i_param_cfg_beats = beats;
        ready_i = pick_ready(mode, 0);
        ready_log[cyc] = ready_i;
        budget = 40 * int'(beats) + 60;
        fin_at = -1;
        done = 1'b0;
        for (int n = 1; n <= budget && !done; n++) begin
            step();
            start_i = 1'b0;
            if (perturb) begin
                i_param_cfg_base = AW'($urandom);
                i_param_cfg_beats = RW'($urandom);
                if (busy_o) start_i = 1'($urandom_range(0, 1));
            end
            ready_i = pick_ready(mode, n);
            ready_log[cyc] = ready_i;
            @(negedge clk_i);
            #1;
            if (fin_at < 0 && fin_log[cyc] === 1'b1) fin_at = cyc;
            if (fin_at >= 0 && cyc >= fin_at + 3) done = 1'b1;
        end
        tend = cyc;
        start_i = 1'b0;
        ready_i = 1'b0;
        checkOutput("finish_seen", done, 1'b1);
    endtask

    task automatic trace_result(input string name, input int mism, input int first);
        if (mism != 0) $display("[TB] %s first differs at rel cycle %0d", name, first);
        checkOutput(name, mism, 0);
    endtask

    // Build the expected timeline from the job rules and compare it with the trace
    task automatic verify_job(input int t0, input int tend, input int base, input int beats, input int fin_rel);
        int t, vs, hs, f, mism, first, nfin, nhs, obs;
        logic [OW-1:0] bd;
        for (int c = t0; c <= tend; c++) begin
            e_en[c] = 1'b0; e_addr[c] = '0; e_valid[c] = 1'b0;
            e_data[c] = '0; e_fin[c] = 1'b0; e_busy[c] = 1'b0;
        end
        t = t0;
        for (int b = 0; b < beats; b++) begin
            for (int k = 0; k < WPB; k++) begin
                if (t + 1 + k <= tend) begin
                    e_en[t+1+k]   = 1'b1;
                    e_addr[t+1+k] = AW'((base + b*WPB + k) % DEPTH);
                end
            end
            bd = model_beat(base, b);
            vs = t + 18;
            hs = vs;
            while (hs <= tend && ready_log[hs] !== 1'b1) hs++;
            for (int c = vs; c <= hs && c <= tend; c++) begin
                e_valid[c] = 1'b1;
                e_data[c]  = bd;
            end
            t = hs;
        end
        f = t + 2;
        for (int c = t0 + 1; c < f && c <= tend; c++) e_busy[c] = 1'b1;
        if (f <= tend) e_fin[f] = 1'b1;

        mism = 0; first = -1;
        for (int c = t0; c <= tend; c++) if (en_log[c] !== e_en[c]) begin mism++; if (first < 0) first = c - t0; end
        trace_result("en_trace", mism, first);
        mism = 0; first = -1;
        for (int c = t0; c <= tend; c++) if (e_en[c] && addr_log[c] !== e_addr[c]) begin mism++; if (first < 0) first = c - t0; end
        trace_result("addr_trace", mism, first);
        mism = 0; first = -1;
        for (int c = t0; c <= tend; c++) if (valid_log[c] !== e_valid[c]) begin mism++; if (first < 0) first = c - t0; end
        trace_result("valid_trace", mism, first);
        mism = 0; first = -1;
        for (int c = t0; c <= tend; c++) if (e_valid[c] && data_log[c] !== e_data[c]) begin mism++; if (first < 0) first = c - t0; end
        trace_result("data_trace", mism, first);
        mism = 0; first = -1;
        for (int c = t0; c <= tend; c++) if (fin_log[c] !== e_fin[c]) begin mism++; if (first < 0) first = c - t0; end
        trace_result("finish_trace", mism, first);
        mism = 0; first = -1;
        for (int c = t0; c <= tend; c++) if (busy_log[c] !== e_busy[c]) begin mism++; if (first < 0) first = c - t0; end
        trace_result("busy_trace", mism, first);

        nfin = 0; nhs = 0; obs = -1;
        for (int c = t0; c <= tend; c++) begin
            if (fin_log[c] === 1'b1) begin nfin++; if (obs < 0) obs = c - t0; end
            if (valid_log[c] === 1'b1 && ready_log[c]) nhs++;
        end
        checkOutput("finish_count", nfin, 1);
        checkOutput("beat_count", nhs, beats);
        checkOutput("busy_after", busy_log[tend], 1'b0);
        if (fin_rel >= 0) checkOutput("finish_cycle", obs, fin_rel);
    endtask

    initial begin
        int t0, tend, mism, rbase, rbeats, rmode, rst_c;
        logic [OW-1:0] ref_beat, tmp;

        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
        for (int k = 0; k < WPB; k++) mem[100 + k] = DW'(k + 1);

        vecs[0] = '{100,  32'd1, 0, 1'b0, 20};
        vecs[1] = '{512,  32'd4, 0, 1'b0, 74};
        vecs[2] = '{300,  32'd1, 2, 1'b0, 30};
        vecs[3] = '{5,    32'd0, 0, 1'b0, 2};
        vecs[4] = '{8184, 32'd1, 0, 1'b0, 20};
        vecs[5] = '{8000, 32'd3, 1, 1'b1, -1};
        vecs[6] = '{4000, 32'd2, 0, 1'b1, 38};

        // Reset values
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_bram_addr", bram_addr, 0);
        checkOutput("rst_bram_en", bram_en, 0);
        checkOutput("rst_bram_we", bram_we, 0);
        checkOutput("rst_valid_o", valid_o, 0);
        checkOutput("rst_finish_o", finish_o, 0);
        checkOutput("rst_busy_o", busy_o, 0);
        checkOutput("rst_data_o", |data_o, 0);
        rst_i = 1'b0;
        step();

        // Table of jobs
        for (int i = 0; i < 7; i++) begin
            $display("[TB] job %0d base=%0d beats=%0d mode=%0d", i, vecs[i].base, vecs[i].beats, vecs[i].mode);
            applyStimulus(vecs[i].base, vecs[i].beats, vecs[i].mode, vecs[i].perturb, t0, tend);
            t0s[i] = t0;
            verify_job(t0, tend, vecs[i].base, int'(vecs[i].beats), vecs[i].fin_rel);
        end

        // Single beat: explicit latency and packing
        t0 = t0s[0];
        checkOutput("single_first_addr", addr_log[t0+1], 100);
        checkOutput("single_last_addr", addr_log[t0+16], 115);
        checkOutput("single_en_c17", en_log[t0+17], 0);
        checkOutput("single_valid_c17", valid_log[t0+17], 0);
        checkOutput("single_valid_c18", valid_log[t0+18], 1);
        tmp = data_log[t0+18];
        mism = 0;
        for (int k = 0; k < WPB; k++) if (tmp[k*DW +: DW] !== DW'(k + 1)) mism++;
        checkOutput("single_words", mism, 0);

        // Backpressure: beat stable, no reads while held
        t0 = t0s[2];
        ref_beat = data_log[t0+18];
        mism = 0;
        for (int c = 18; c <= 28; c++) if (data_log[t0+c] !== ref_beat || en_log[t0+c] !== 1'b0) mism++;
        checkOutput("hold_stable", mism, 0);
        checkOutput("hold_drop_c29", valid_log[t0+29], 0);

        // Wrap at the top of the address space
        t0 = t0s[4];
        checkOutput("wrap_top", addr_log[t0+8], 8191);
        checkOutput("wrap_zero", addr_log[t0+9], 0);

        // Random jobs with config scrambling and stray starts
        for (int i = 0; i < 10; i++) begin
            rbase  = $urandom_range(0, DEPTH - 1);
            rbeats = $urandom_range(0, 3);
            rmode  = $urandom_range(0, 1);
            applyStimulus(rbase, 32'(rbeats), rmode, 1'b1, t0, tend);
            verify_job(t0, tend, rbase, rbeats, -1);
        end

        // Mid-job reset during the second beat's fetch, with a huge beat count
        step();
        t0 = cyc;
        start_i = 1'b1;
        i_param_cfg_base = AW'(1000);
        i_param_cfg_beats = 32'hFFFF_FFFF;
        ready_i = 1'b1;
        ready_log[cyc] = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            step();
            start_i = (n == 5 || n == 21);
            i_param_cfg_base = AW'($urandom);
            i_param_cfg_beats = RW'($urandom);
            ready_log[cyc] = 1'b1;
            if (n == 25) begin
                rst_i = 1'b1;
                #1;
                checkOutput("abort_bram_en", bram_en, 0);
                checkOutput("abort_bram_addr", bram_addr, 0);
                checkOutput("abort_valid_o", valid_o, 0);
                checkOutput("abort_busy_o", busy_o, 0);
                checkOutput("abort_data_o", |data_o, 0);
            end
        end
        rst_c = cyc;
        start_i = 1'b0;
        ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        repeat (6) step();
        @(negedge clk_i);
        #1;
        checkOutput("abort_addr_c6", addr_log[t0+6], 1005);
        checkOutput("abort_valid_c18", valid_log[t0+18], 1);
        checkOutput("abort_en_c19", en_log[t0+19], 1);
        checkOutput("abort_addr_c24", addr_log[t0+24], 1021);
        mism = 0;
        for (int c = t0; c <= cyc; c++) if (fin_log[c] !== 1'b0) mism++;
        checkOutput("abort_no_finish", mism, 0);
        mism = 0;
        for (int c = rst_c; c <= cyc; c++) if (en_log[c] !== 1'b0 || busy_log[c] !== 1'b0) mism++;
        checkOutput("abort_quiet", mism, 0);

        // Fresh job after the reset
        applyStimulus(1234, 32'd2, 0, 1'b0, t0, tend);
        verify_job(t0, tend, 1234, 2, 38);

        checkOutput("bram_we_low", we_bad, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
